data_mem_responder: RTL

- Responder on the CPU data-memory bus (ram_ce/ram_we/ram_sel/ram_addr_i/ram_data_i in, ram_data_o out).
- Serves a word-organised RAM with big-endian byte-lane writes.
- Serves a memory-mapped I/O window holding a cycle counter, a compare/interrupt unit and a console TX FIFO, drained through a valid/ready port.
- Sits beside the core at top level, in place of a bare RAM model.

---
 rtl/data_mem_responder_pkg.sv | 27 ++
 rtl/data_mem_responder_if.sv | 19 +
 rtl/data_mem_responder_tx_fifo.sv | 50 +++++
 rtl/data_mem_responder.sv | 115 +++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: I/O window base, register
// word offsets and CTRL/STAT bit positions used by both RTL and software tests.
package data_mem_responder_pkg;

    localparam logic [15:0] IO_BASE_DEFAULT = 16'h1000;

    typedef enum logic [1:0] {
        REG_CNT    = 2'd0,
        REG_CMP    = 2'd1,
        REG_CTRL   = 2'd2,
        REG_TXDATA = 2'd3
    } io_reg_e;

    localparam int CTRL_CMP_EN  = 0;
    localparam int CTRL_IRQ     = 1;
    localparam int CTRL_FULL    = 2;
    localparam int CTRL_EMPTY   = 3;
    localparam int CTRL_OVF     = 4;
    localparam int CTRL_CNT_LSB = 5;
    localparam int CTRL_CNT_MSB = 8;

    // The STAT count field is only four bits wide, so larger depths show 15.
    function automatic logic [3:0] sat_count(input logic [31:0] c);
        return (c > 32'd15) ? 4'hF : c[3:0];
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU data-memory bus as seen between the core (master) and the responder (slave).
interface data_mem_if;
    logic        ram_ce;
    logic        ram_we;
    logic [3:0]  ram_sel;
    logic [31:0] ram_addr_i;
    logic [31:0] ram_data_i;
    logic [31:0] ram_data_o;

    modport master (
        output ram_ce, ram_we, ram_sel, ram_addr_i, ram_data_i,
        input  ram_data_o
    );

    modport slave (
        input  ram_ce, ram_we, ram_sel, ram_addr_i, ram_data_i,
        output ram_data_o
    );
endinterface

// File: rtl/data_mem_responder_tx_fifo.sv
// Console TX byte FIFO; a push into a full FIFO is dropped (flagged on drop)
// unless a pop happens in the same cycle.
module tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [7:0]               data_in,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    // Head reads zero while empty so the consumer never sees stale bytes.
    assign head    = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM with big-endian byte-lane writes plus an I/O
// window holding a cycle counter, compare/interrupt unit and console TX FIFO.
// TX handshake: a byte transfers on any rising edge where tx_valid && tx_ready;
// tx_valid never depends on tx_ready and tx_data is stable while tx_valid waits.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int          ADDR_W     = 10,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] IO_BASE    = IO_BASE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    data_mem_if.slave  bus,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    output logic       irq_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic              io_hit, io_sel, ram_wr, io_wr, ctrl_wr, fifo_push;
    logic              irq_set, fifo_full, fifo_empty, fifo_drop;
    logic [CW-1:0]     fifo_count;
    logic [ADDR_W-1:0] word_idx;
    io_reg_e           io_off;
    logic [31:0]       cnt, cmp, stat_word, rdata;
    logic              cmp_en, irq, ovf;
    logic [31:0]       mem [2**ADDR_W];
    logic              unused_addr_bits;

    assign io_hit    = (bus.ram_addr_i[31:16] == IO_BASE);
    assign io_sel    = io_hit && (bus.ram_addr_i[15:4] == 12'd0);
    assign io_off    = io_reg_e'(bus.ram_addr_i[3:2]);
    assign word_idx  = bus.ram_addr_i[ADDR_W+1:2];
    assign ram_wr    = bus.ram_ce && bus.ram_we && !io_hit;
    assign io_wr     = bus.ram_ce && bus.ram_we && io_sel;
    assign ctrl_wr   = io_wr && (io_off == REG_CTRL);
    assign fifo_push = io_wr && (io_off == REG_TXDATA) && bus.ram_sel[0];
    assign irq_set   = cmp_en && (cnt == cmp);
    assign unused_addr_bits = &{1'b0, bus.ram_addr_i[1:0]};

    // Lane b covers data[8b+7:8b]; sel[3] is the byte at offset 0 (big-endian).
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.ram_sel[b]) mem[word_idx][8*b +: 8] <= bus.ram_data_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            cmp    <= '0;
            cmp_en <= 1'b0;
            irq    <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (io_wr && io_off == REG_CNT) cnt <= bus.ram_data_i;
            else                            cnt <= cnt + 32'd1;
            if (io_wr && io_off == REG_CMP) cmp <= bus.ram_data_i;
            if (ctrl_wr) cmp_en <= bus.ram_data_i[CTRL_CMP_EN];
            // Setting events win over a simultaneous write-1-to-clear.
            if (irq_set)                                  irq <= 1'b1;
            else if (ctrl_wr && bus.ram_data_i[CTRL_IRQ]) irq <= 1'b0;
            if (fifo_drop)                                ovf <= 1'b1;
            else if (ctrl_wr && bus.ram_data_i[CTRL_OVF]) ovf <= 1'b0;
        end
    end

    tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push    (fifo_push),
        .data_in (bus.ram_data_i[7:0]),
        .pop     (tx_ready),
        .head    (tx_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count),
        .drop    (fifo_drop)
    );

    assign tx_valid = !fifo_empty;
    assign irq_o    = irq;

    always_comb begin
        stat_word = '0;
        stat_word[CTRL_CMP_EN] = cmp_en;
        stat_word[CTRL_IRQ]    = irq;
        stat_word[CTRL_FULL]   = fifo_full;
        stat_word[CTRL_EMPTY]  = fifo_empty;
        stat_word[CTRL_OVF]    = ovf;
        stat_word[CTRL_CNT_MSB:CTRL_CNT_LSB] = sat_count(32'(fifo_count));
    end

    always_comb begin
        rdata = '0;
        if (bus.ram_ce && !bus.ram_we) begin
            if (!io_hit) begin
                rdata = mem[word_idx];
            end else if (io_sel) begin
                case (io_off)
                    REG_CNT:  rdata = cnt;
                    REG_CMP:  rdata = cmp;
                    REG_CTRL: rdata = stat_word;
                    default:  rdata = '0;
                endcase
            end
        end
    end

    assign bus.ram_data_o = rdata;
endmodule
